// File: rtl/imem_dmem_bus_arbiter.sv
// Shares one single-port memory bus between fetch and the memory stage.
// One transaction in flight; data wins ties because it is the older instruction.
module imem_dmem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    input  logic                  inst_cancel,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_data_ok,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [DATA_W/8-1:0]   data_wen,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_data_ok,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        I_ADDR,
        I_WAIT,
        D_ADDR,
        D_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                inst_ok_q, inst_ok_d;
    logic                data_ok_q, data_ok_d;
    logic                cancel_q, cancel_d;
    logic                data_go;
    logic                inst_go;

    // A requester still holding req during its own completion pulse is not regranted.
    assign data_go = data_req & ~data_ok_q;
    assign inst_go = inst_req & ~inst_ok_q & ~inst_cancel;

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ok_d    = 1'b0;
        data_ok_d    = 1'b0;
        cancel_d     = cancel_q;
        case (state_q)
            IDLE: begin
                if (data_go) begin
                    wr_d    = data_wr;
                    wstrb_d = data_wr ? data_wen : '0;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    state_d = D_ADDR;
                end else if (inst_go) begin
                    wr_d     = 1'b0;
                    wstrb_d  = '0;
                    addr_d   = inst_addr;
                    wdata_d  = '0;
                    cancel_d = 1'b0;
                    state_d  = I_ADDR;
                end
            end
            I_ADDR: begin
                if (inst_cancel) cancel_d = 1'b1;
                if (bus_addr_ok) state_d = I_WAIT;
            end
            I_WAIT: begin
                if (bus_data_ok) begin
                    if (!(cancel_q || inst_cancel)) begin
                        inst_rdata_d = bus_rdata;
                        inst_ok_d    = 1'b1;
                    end
                    cancel_d = 1'b0;
                    state_d  = IDLE;
                end else if (inst_cancel) begin
                    cancel_d = 1'b1;
                end
            end
            D_ADDR: begin
                if (bus_addr_ok) state_d = D_WAIT;
            end
            D_WAIT: begin
                if (bus_data_ok) begin
                    data_rdata_d = bus_rdata;
                    data_ok_d    = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            cancel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
            cancel_q     <= cancel_d;
        end
    end

    assign bus_req      = (state_q == I_ADDR) || (state_q == D_ADDR);
    assign bus_wr       = wr_q;
    assign bus_wstrb    = wstrb_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign inst_rdata   = inst_rdata_q;
    assign inst_data_ok = inst_ok_q;
    assign data_rdata   = data_rdata_q;
    assign data_data_ok = data_ok_q;
    assign stall_if     = inst_req & ~inst_ok_q;
    assign stall_mem    = data_req & ~data_ok_q;

endmodule
